// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write bus of prog_loader.
interface prog_loader_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_W     = 5
) ();
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  cpu_hold;
   logic                  done;
   logic                  err;

   modport master (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing MSB-first instruction words into program memory.
// Define PROG_LOADER_CSUM_EN to add the trailing checksum byte and the err flag.
module prog_loader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter logic [7:0]  START_BYTE = 8'hA5
) (
   input logic          clk,
   input logic          rst,
   prog_loader_if.master bus
);
   localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
   localparam int unsigned SHIFT_W        = DATA_WIDTH - 8;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  in_ready_q, in_ready_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q, done_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [ADDR_W-1:0]     last_addr_q, last_addr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [SHIFT_W-1:0]    shift_q, shift_d;
`ifdef PROG_LOADER_CSUM_EN
   logic [7:0]            acc_q, acc_d;
   logic                  err_q, err_d;
   logic [7:0]            csum_c;
`else
   // Set on the final word write so the done pulse lands one cycle after mem_we.
   logic                  flush_q, flush_d;
`endif
   logic                  fire_c;
   logic [DATA_WIDTH-1:0] word_c;

   assign fire_c = bus.in_valid & in_ready_q;
   assign word_c = {shift_q, bus.in_data};
`ifdef PROG_LOADER_CSUM_EN
   assign csum_c = acc_q + bus.in_data;
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b0;
         done_q      <= 1'b0;
         addr_q      <= '0;
         last_addr_q <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
`ifdef PROG_LOADER_CSUM_EN
         acc_q       <= '0;
         err_q       <= 1'b0;
`else
         flush_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         done_q      <= done_d;
         addr_q      <= addr_d;
         last_addr_q <= last_addr_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
`ifdef PROG_LOADER_CSUM_EN
         acc_q       <= acc_d;
         err_q       <= err_d;
`else
         flush_q     <= flush_d;
`endif
      end
   end

   // Frame parser: next state and next registered outputs.
   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      done_d      = 1'b0;
      addr_d      = addr_q;
      last_addr_d = last_addr_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
`ifdef PROG_LOADER_CSUM_EN
      acc_d       = acc_q;
      err_d       = err_q;
`else
      flush_d     = flush_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (fire_c && (bus.in_data == START_BYTE)) begin
               state_d    = S_COUNT;
               cpu_hold_d = 1'b1;
               addr_d     = '0;
               idx_d      = '0;
`ifdef PROG_LOADER_CSUM_EN
               acc_d      = '0;
               err_d      = 1'b0;
`endif
            end
         end

         S_COUNT: begin
            // COUNT of 0 wraps to the top address, i.e. a full 32-word frame.
            if (fire_c) begin
               last_addr_d = ADDR_W'(bus.in_data - 8'd1);
               state_d     = S_DATA;
            end
         end

         S_DATA: begin
`ifndef PROG_LOADER_CSUM_EN
            if (flush_q) begin
               flush_d    = 1'b0;
               state_d    = S_DONE;
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
            end else
`endif
            if (fire_c) begin
               shift_d = SHIFT_W'({shift_q, bus.in_data});
               idx_d   = idx_q + IDX_W'(1);
`ifdef PROG_LOADER_CSUM_EN
               acc_d   = acc_q + bus.in_data;
`endif
               if (idx_q == LAST_IDX) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = word_c;
                  if (addr_q == last_addr_q) begin
`ifdef PROG_LOADER_CSUM_EN
                     state_d = S_CSUM;
`else
                     flush_d = 1'b1;
`endif
                  end else begin
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
         end

`ifdef PROG_LOADER_CSUM_EN
         S_CSUM: begin
            if (fire_c) begin
               state_d = S_DONE;
               if (csum_c == 8'd0) begin
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
`endif

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d != S_DONE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_hold  = cpu_hold_q;
   assign bus.done      = done_q;
`ifdef PROG_LOADER_CSUM_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frame-level reference model checked every cycle.
module tb_prog_loader;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_W     = 5;
`ifdef PROG_LOADER_CSUM_EN
   localparam int DONE_LAT = 0;
`else
   localparam int DONE_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;

   prog_loader_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) bus ();

   prog_loader #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_W    (ADDR_W),
      .START_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit chk_en      = 1'b0;

   // Expected outputs for the cycle following the latest rising edge.
   logic              exp_ready = 1'b1;
   logic              exp_we    = 1'b0;
   logic [ADDR_W-1:0] exp_addr  = '0;
   logic [31:0]       exp_wdata = '0;
   logic              exp_hold  = 1'b0;
   logic              exp_done  = 1'b0;
   logic              exp_err   = 1'b0;

   // Frame-level view: which bytes of the current frame have arrived.
   bit         in_frame   = 1'b0;
   bit         have_count = 1'b0;
   bit         fin_wait   = 1'b0;
   int         total_words = 0;
   int         data_cnt   = 0;
   logic [7:0] sum        = '0;
   logic [7:0] fb[$];
   logic [31:0] exp_mem[32];
   logic [31:0] dut_mem[32];

   int  wr_count = 0, done_count = 0, last_wr_addr = -1;
   int  acc_cyc = 0, done_cyc = 0;
   bit  alt_gap = 1'b0;
   logic [7:0] payload[$];

   task automatic finish_frame(input bit pass);
      if (pass) begin
         exp_done = 1'b1;
         exp_hold = 1'b0;
      end else begin
         exp_err = 1'b1;
      end
      exp_ready = 1'b0;
      in_frame  = 1'b0;
   endtask

   // Reference model: consumes every transferred byte at the rising edge.
   always @(posedge clk) begin : model
      bit fire;
      logic [7:0] b;
      fire = (exp_ready === 1'b1) && (bus.in_valid === 1'b1);
      b    = bus.in_data;
      cyc++;
      if (rst) begin
         chk_en = 1'b1;
         exp_ready = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
         exp_hold = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
         in_frame = 1'b0; have_count = 1'b0; fin_wait = 1'b0;
      end else begin
         exp_we = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
         if (fin_wait) begin
            fin_wait = 1'b0;
            finish_frame(1'b1);
         end else if (fire) begin
            if (!in_frame) begin
               if (b == 8'hA5) begin
                  in_frame = 1'b1; have_count = 1'b0; data_cnt = 0; sum = '0;
                  exp_hold = 1'b1; exp_err = 1'b0;
                  fb.delete();
               end
            end else if (!have_count) begin
               total_words = (b == 8'd0) ? 32 : int'(b);
               have_count  = 1'b1;
            end else if (data_cnt < 4 * total_words) begin
               fb.push_back(b);
               data_cnt++;
               sum += b;
               if (data_cnt % 4 == 0) begin
                  exp_we    = 1'b1;
                  exp_addr  = ADDR_W'(data_cnt / 4 - 1);
                  exp_wdata = {fb[data_cnt-4], fb[data_cnt-3], fb[data_cnt-2], fb[data_cnt-1]};
                  exp_mem[data_cnt/4-1] = exp_wdata;
`ifndef PROG_LOADER_CSUM_EN
                  if (data_cnt == 4 * total_words) fin_wait = 1'b1;
`endif
               end
            end else begin
               finish_frame(8'(sum + b) == 8'd0);
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin : compare
      if (chk_en) begin
         vectors++;
         if (bus.in_ready !== exp_ready || bus.mem_we !== exp_we || bus.mem_addr !== exp_addr ||
             bus.mem_wdata !== exp_wdata || bus.cpu_hold !== exp_hold || bus.done !== exp_done ||
             bus.err !== exp_err) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got rdy=%b we=%b addr=%0d wdata=%h hold=%b done=%b err=%b, want rdy=%b we=%b addr=%0d wdata=%h hold=%b done=%b err=%b",
                     cyc, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_hold, bus.done, bus.err,
                     exp_ready, exp_we, exp_addr, exp_wdata, exp_hold, exp_done, exp_err);
         end
         if (bus.mem_we === 1'b1) begin
            dut_mem[bus.mem_addr] = bus.mem_wdata;
            wr_count++;
            last_wr_addr = int'(bus.mem_addr);
         end
         if (bus.done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      bit sent;
      sent = 1'b0;
      if (alt_gap) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
      end else begin
         while ($urandom_range(0, 99) < idle) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 8 && !sent; t++) begin
         sent = (bus.in_ready === 1'b1);
         @(negedge clk);
      end
      if (sent) acc_cyc = cyc;
      else begin
         vectors++;
         miscompares++;
         $display("FAIL send_byte: byte %h not accepted within 8 cycles", b);
      end
   endtask

   task automatic idle_cycles(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] cnt, input bit good, input int idle);
      logic [7:0] s;
      s = '0;
      send_byte(8'hA5, idle);
      send_byte(cnt, idle);
      foreach (payload[i]) begin
         send_byte(payload[i], idle);
         s += payload[i];
      end
`ifdef PROG_LOADER_CSUM_EN
      send_byte(good ? 8'(8'd0 - s) : 8'(8'd1 - s), idle);
`else
      if (good) s = '0;
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int d0, w0, n;
      logic [7:0] g;
      for (int i = 0; i < 32; i++) begin
         exp_mem[i] = '0;
         dut_mem[i] = '0;
      end
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_cpu_hold", 32'(bus.cpu_hold), 32'd0);
      rst = 1'b0;

      // Non-start bytes in idle are swallowed.
      send_byte(8'h00, 0);
      send_byte(8'h3C, 0);
      idle_cycles(3);
      check("idle_no_write", 32'(wr_count), 32'd0);
      check("idle_cpu_hold", 32'(bus.cpu_hold), 32'd0);

      // Two-word frame at full rate.
      d0 = done_count; w0 = wr_count;
      payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_frame(8'h02, 1'b1, 0);
      idle_cycles(6);
      check("frame2_word0", dut_mem[0], 32'h11223344);
      check("frame2_word1", dut_mem[1], 32'h55667788);
      check("frame2_writes", 32'(wr_count - w0), 32'd2);
      check("frame2_done", 32'(done_count - d0), 32'd1);
      check("frame2_done_latency", 32'(done_cyc - acc_cyc), 32'(DONE_LAT));

      // 32-word frame with valid dropping every other cycle.
      d0 = done_count; w0 = wr_count;
      payload.delete();
      for (int i = 0; i < 128; i++) payload.push_back(8'($urandom_range(0, 255)));
      alt_gap = 1'b1;
      send_frame(8'h00, 1'b1, 0);
      alt_gap = 1'b0;
      idle_cycles(6);
      check("frame32_writes", 32'(wr_count - w0), 32'd32);
      check("frame32_last_addr", 32'(last_wr_addr), 32'd31);
      check("frame32_done", 32'(done_count - d0), 32'd1);

`ifdef PROG_LOADER_CSUM_EN
      // Good then bad checksum on the same one-word frame.
      d0 = done_count;
      payload = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(8'h01, 1'b1, 0);
      idle_cycles(6);
      check("csum_good_done", 32'(done_count - d0), 32'd1);
      check("csum_good_err", 32'(bus.err), 32'd0);
      d0 = done_count; w0 = wr_count;
      send_frame(8'h01, 1'b0, 0);
      idle_cycles(6);
      check("csum_bad_err", 32'(bus.err), 32'd1);
      check("csum_bad_hold", 32'(bus.cpu_hold), 32'd1);
      check("csum_bad_no_done", 32'(done_count - d0), 32'd0);
      check("csum_bad_write", 32'(wr_count - w0), 32'd1);
      check("csum_bad_word0", dut_mem[0], 32'h01020304);
`endif

      // Reset after six data bytes of a two-word frame.
      w0 = wr_count;
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
      foreach (payload[i]) send_byte(payload[i], 0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_hold", 32'(bus.cpu_hold), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      idle_cycles(2);
      check("rst_writes", 32'(wr_count - w0), 32'd1);
      check("rst_word0", dut_mem[0], 32'hDEADBEEF);
      d0 = done_count;
      payload = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
      send_frame(8'h01, 1'b1, 0);
      idle_cycles(6);
      check("post_rst_word0", dut_mem[0], 32'hCAFEBABE);
      check("post_rst_done", 32'(done_count - d0), 32'd1);

      // Start marker inside the data is plain data.
      d0 = done_count;
      payload = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
      send_frame(8'h01, 1'b1, 0);
      idle_cycles(6);
      check("a5_data_word0", dut_mem[0], 32'hA5A5A5A5);
      check("a5_data_done", 32'(done_count - d0), 32'd1);

      // Random frames with idle noise, random gaps and random checksum quality.
      for (int f = 0; f < 10; f++) begin
         repeat ($urandom_range(0, 3)) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 30);
         end
         n = $urandom_range(1, 6);
         payload.delete();
         for (int i = 0; i < 4 * n; i++)
            payload.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
         send_frame(8'(n), $urandom_range(0, 3) != 0, $urandom_range(0, 60));
         idle_cycles(6);
      end

      for (int i = 0; i < 32; i++) check($sformatf("mem_%0d", i), dut_mem[i], exp_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
